parallel_to_serial: RTL and testbench

- Converts `width`-bit parallel words into a one-bit serial stream with a valid qualifier, MSB first.
- Serves as the transmit-side counterpart of the serial-to-parallel deserializer. Output feeds that block's serial_valid/serial_data directly, and a round trip reproduces each word bit-exact.
- Accepts words over a valid/ready handshake.
- Holds a one-word buffer so a continuous input stream produces a gap-free serial stream.

---
 rtl/parallel_to_serial_if.sv | 22 ++
 rtl/parallel_to_serial.sv | 84 ++++++++
 tb/tb_parallel_to_serial.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_if.sv
// Handshake bundle for the serializer: parallel words in over valid/ready,
// one valid-qualified serial bit per cycle out, plus an activity flag.
interface parallel_to_serial_if #(
   parameter int width = 8
);
   logic             parallel_valid;
   logic [width-1:0] parallel_data;
   logic             parallel_ready;
   logic             serial_valid;
   logic             serial_data;
   logic             busy;

   modport master (
      output parallel_valid, parallel_data,
      input  parallel_ready, serial_valid, serial_data, busy
   );

   modport slave (
      input  parallel_valid, parallel_data,
      output parallel_ready, serial_valid, serial_data, busy
   );
endinterface

// File: rtl/parallel_to_serial.sv
// MSB-first parallel-to-serial converter with a one-word holding buffer so a
// continuous upstream stream yields a gap-free serial stream.
module parallel_to_serial #(
   parameter int width = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   parallel_to_serial_if.slave  bus
);

   localparam int CW = $clog2(width) + 1;

   logic [width-1:0] shift_q,     shift_d;
   logic [width-1:0] hold_q,      hold_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic             active_q,    active_d;
   logic             hold_full_q, hold_full_d;

   logic last_bit;
   logic free;
   logic accept;

   assign last_bit = active_q && (cnt_q == CW'(width - 1));
   assign free     = !active_q || last_bit;
   assign accept   = bus.parallel_valid && !hold_full_q;

   assign bus.parallel_ready = !hold_full_q;
   assign bus.serial_valid   = active_q;
   assign bus.serial_data    = active_q & shift_q[width-1];
   assign bus.busy           = active_q | hold_full_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // this block leaves a value unassigned and infers a latch.
      shift_d     = shift_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      active_d    = active_q;
      hold_full_d = hold_full_q;

      if (free) begin
         if (hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            active_d    = 1'b1;
            hold_full_d = 1'b0;
         end else if (accept) begin
            // Buffer empty: a word arriving as the shifter frees skips the hold stage.
            shift_d  = bus.parallel_data;
            cnt_d    = '0;
            active_d = 1'b1;
         end else begin
            active_d = 1'b0;
            cnt_d    = '0;
         end
      end else begin
         shift_d = shift_q << 1;
         cnt_d   = cnt_q + CW'(1);
         if (accept) begin
            hold_d      = bus.parallel_data;
            hold_full_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q     <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         active_q    <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         hold_full_q <= hold_full_d;
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench: a queue-of-bits model checks the width-8 instance every
// cycle; directed scenarios pin the model with hand-computed literals.
module tb_parallel_to_serial;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   parallel_to_serial_if #(.width(W)) bus8 ();
   parallel_to_serial_if #(.width(1)) bus1 ();

   parallel_to_serial #(.width(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   parallel_to_serial #(.width(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every bit still owed on the serial line, front = bit shown this cycle.
   bit q[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
      end else begin
         bit rdy;
         rdy = (q.size() <= W);
         if (q.size() > 0) void'(q.pop_front());
         if (bus8.parallel_valid && rdy)
            for (int i = W - 1; i >= 0; i--) q.push_back(bus8.parallel_data[i]);
      end
   end

   // Reference deserializer and stream statistics.
   logic [W-1:0] rx_word = '0;
   int           rx_cnt  = 0;
   logic [W-1:0] rx_words[$];
   int           run_len = 0;
   int           max_run = 0;
   bit           ready_low_seen = 1'b0;
   bit           valid_seen     = 1'b0;

   always @(negedge clk) begin
      check("model_ready", bus8.parallel_ready, q.size() <= W);
      check("model_valid", bus8.serial_valid,   q.size() > 0);
      check("model_data",  bus8.serial_data,    (q.size() > 0) ? q[0] : 1'b0);
      check("model_busy",  bus8.busy,           q.size() > 0);

      if (!rst) begin
         rx_cnt  = 0;
         run_len = 0;
      end else begin
         if (!bus8.parallel_ready) ready_low_seen = 1'b1;
         if (bus8.serial_valid) begin
            valid_seen = 1'b1;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            rx_word = {rx_word[W-2:0], bus8.serial_data};
            rx_cnt++;
            if (rx_cnt == W) begin
               rx_words.push_back(rx_word);
               rx_cnt = 0;
            end
         end else begin
            run_len = 0;
         end
      end
   end

   task automatic send8(input logic [W-1:0] w, input bit keep_valid);
      int  n    = 0;
      bit  done = 1'b0;
      bus8.parallel_valid = 1'b1;
      bus8.parallel_data  = w;
      while (!done) begin
         @(negedge clk);
         done = bus8.parallel_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout word=%0h never accepted", w);
            done = 1'b1;
         end
      end
      if (!keep_valid) bus8.parallel_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [W-1:0] got;
      logic [W-1:0] sent[$];
      logic [3:0]   pat;
      int           base;
      int           budget;

      bus8.parallel_valid = 1'b0;
      bus8.parallel_data  = '0;
      bus1.parallel_valid = 1'b0;
      bus1.parallel_data  = '0;

      // Reset behaviour: held low 3 cycles, then released with no input.
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            @(posedge clk);
            #1 rst = 1'b1;
         end
         @(negedge clk);
         check("rst_valid8", bus8.serial_valid,   1'b0);
         check("rst_busy8",  bus8.busy,           1'b0);
         check("rst_ready8", bus8.parallel_ready, 1'b1);
         check("rst_valid1", bus1.serial_valid,   1'b0);
         check("rst_ready1", bus1.parallel_ready, 1'b1);
      end
      @(posedge clk);
      #1;

      // Single word A5: MSB appears in the cycle after acceptance.
      send8(8'hA5, 1'b0);
      got = '0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("single_valid", bus8.serial_valid, 1'b1);
         got = {got[W-2:0], bus8.serial_data};
      end
      check("single_bits", got, 8'hA5);
      @(negedge clk);
      check("single_end_valid", bus8.serial_valid, 1'b0);
      check("single_end_busy",  bus8.busy,         1'b0);
      idle(3);

      // Back-to-back: FF, 00, 3C with valid held high.
      base           = rx_words.size();
      max_run        = 0;
      ready_low_seen = 1'b0;
      send8(8'hFF, 1'b1);
      send8(8'h00, 1'b1);
      send8(8'h3C, 1'b0);
      idle(30);
      check("b2b_run",       max_run, 24);
      check("b2b_ready_low", ready_low_seen, 1'b1);
      check("b2b_count",     rx_words.size() - base, 3);
      if (rx_words.size() >= base + 3) begin
         check("b2b_w0", rx_words[base],     8'hFF);
         check("b2b_w1", rx_words[base + 1], 8'h00);
         check("b2b_w2", rx_words[base + 2], 8'h3C);
      end

      // Round trip: 100 random words with random idle gaps.
      base = rx_words.size();
      for (int k = 0; k < 100; k++) begin
         int gap;
         logic [W-1:0] w;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            bus8.parallel_data = W'($urandom);
            idle(1);
         end
         w = W'($urandom);
         sent.push_back(w);
         send8(w, 1'b0);
      end
      budget = 0;
      while (rx_words.size() < base + 100 && budget < 2000) begin
         idle(1);
         budget++;
      end
      check("rt_count", rx_words.size() - base, 100);
      for (int k = 0; k < 100; k++)
         if (base + k < rx_words.size()) check("rt_word", rx_words[base + k], sent[k]);
      idle(3);

      // Reset mid-word: C3 shifting, 81 in the buffer, reset after 3 bits.
      send8(8'hC3, 1'b1);
      send8(8'h81, 1'b0);
      @(negedge clk);
      check("mid_busy_before", bus8.busy, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      #2 rst = 1'b0;
      base = rx_words.size();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      valid_seen = 1'b0;
      idle(20);
      @(negedge clk);
      check("mid_no_valid", valid_seen,            1'b0);
      check("mid_busy",     bus8.busy,             1'b0);
      check("mid_valid",    bus8.serial_valid,     1'b0);
      check("mid_words",    rx_words.size() - base, 0);
      @(posedge clk);
      #1;

      // Width 1: every active cycle is a last bit, ready stays high.
      pat = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         bus1.parallel_valid = 1'b1;
         bus1.parallel_data  = pat[3-i];
         @(negedge clk);
         check("w1_ready", bus1.parallel_ready, 1'b1);
         if (i > 0) begin
            check("w1_valid", bus1.serial_valid, 1'b1);
            check("w1_data",  bus1.serial_data,  pat[4-i]);
         end
         @(posedge clk);
         #1;
      end
      bus1.parallel_valid = 1'b0;
      @(negedge clk);
      check("w1_ready_last", bus1.parallel_ready, 1'b1);
      check("w1_valid_last", bus1.serial_valid,   1'b1);
      check("w1_data_last",  bus1.serial_data,    pat[0]);
      @(negedge clk);
      check("w1_idle_valid", bus1.serial_valid, 1'b0);
      check("w1_idle_busy",  bus1.busy,         1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
